// File: rtl/lcd_bus_arbiter.sv
// Two-port arbiter and write-timing generator for the ST7920 8-bit parallel bus.
// Define LCD_BUS_LOCK_EN to let an owner keep the bus across several writes via req_lock.
`timescale 1ns/1ps

module lcd_bus_arbiter #(
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 25,
    parameter int T_HOLD  = 5,
    parameter int T_EXEC  = 3600,
    parameter int T_CLEAR = 80000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_db,
    input  logic [1:0]  req_lock,
    output logic [1:0]  req_ready,
    output logic [1:0]  req_done,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_db,
    output logic        lcd_psb
);

    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_B = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
    localparam int MAX_C = (MAX_B > T_EXEC) ? MAX_B : T_EXEC;
    localparam int MAX_T = (MAX_C > T_CLEAR) ? MAX_C : T_CLEAR;
    localparam int CW    = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          owner, last;
    logic [1:0]    rr_grant, grant;
    logic          accept, sel, clear_cmd, phase_end;

    always_comb begin
        rr_grant = 2'b00;
        case (req_valid)
            2'b01:   rr_grant = 2'b01;
            2'b10:   rr_grant = 2'b10;
            2'b11:   rr_grant = last ? 2'b01 : 2'b10;
            default: rr_grant = 2'b00;
        endcase
    end

`ifdef LCD_BUS_LOCK_EN
    logic lock_active, lock_owner, lock_hold;

    // The lock persists while the owner is still asking or still holds req_lock.
    assign lock_hold = lock_active & (req_valid[lock_owner] | req_lock[lock_owner]);
    assign grant     = lock_hold ? (req_valid & (lock_owner ? 2'b10 : 2'b01)) : rr_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (accept) begin
            lock_active <= req_lock[sel];
            lock_owner  <= sel;
        end else if (state == IDLE && lock_active && !req_valid[lock_owner] && !req_lock[lock_owner]) begin
            lock_active <= 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign grant       = rr_grant;
`endif

    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel       = req_ready[1];
    assign clear_cmd = !lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02);
    assign phase_end = (cnt == '0);

    always_comb begin
        state_next = state;
        cnt_next   = phase_end ? '0 : cnt - 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                    cnt_next   = CW'(T_SETUP - 1);
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_next = PULSE;
                    cnt_next   = CW'(T_PULSE - 1);
                end
            end
            PULSE: begin
                if (phase_end) begin
                    state_next = HOLD;
                    cnt_next   = CW'(T_HOLD - 1);
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_next = WAIT;
                    cnt_next   = clear_cmd ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
                end
            end
            WAIT: begin
                if (phase_end) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // lcd_rs/lcd_db double as the request latch, so they stay put until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            owner  <= 1'b0;
            lcd_en <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= 8'h00;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            lcd_en <= (state_next == PULSE);
            if (accept) begin
                owner  <= sel;
                last   <= sel;
                lcd_rs <= req_rs[sel];
                lcd_db <= sel ? req_db[15:8] : req_db[7:0];
            end
        end
    end

    assign req_done = (state == WAIT && phase_end && !rst) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy     = (state != IDLE);
    assign lcd_rw   = 1'b0;
    assign lcd_psb  = 1'b1;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomised and directed bench for lcd_bus_arbiter against a transaction-level model.
// Honours LCD_BUS_LOCK_EN in the model so either build can be checked.
`timescale 1ns/1ps

module tb_lcd_bus_arbiter;

    localparam int TS = 2;
    localparam int TP = 3;
    localparam int TH = 1;
    localparam int TE = 10;
    localparam int TC = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_rs = 2'b00;
    logic [15:0] req_db = 16'h0000;
    logic [1:0]  req_lock = 2'b00;
    logic [1:0]  req_ready, req_done;
    logic        busy, lcd_rs, lcd_rw, lcd_en, lcd_psb;
    logic [7:0]  lcd_db;

    lcd_bus_arbiter #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_CLEAR(TC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rs(req_rs), .req_db(req_db), .req_lock(req_lock),
        .req_ready(req_ready), .req_done(req_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_db(lcd_db), .lcd_psb(lcd_psb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: one outstanding write described by its accept cycle and total length.
    int       cyc = 0;
    bit       chk_en = 0;
    bit       m_active = 0;
    int       m_acc_cyc = 0;
    int       m_dur = 0;
    int       m_owner = 0;
    int       m_last = 1;
    bit       m_rs = 0;
    bit [7:0] m_db = 8'h00;
    bit       m_lock_act = 0;
    int       m_lock_own = 0;
    int       m_acc_cnt[2] = '{0, 0};

    // Timing observed on the DUT pins, compared later against hand-computed figures.
    int d_acc_cyc = 0;
    int d_rise = -1;
    int d_len = 0;
    int d_done = -1;
    bit d_prev_en = 0;
    int d_owners[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [1:0] modelGrant();
`ifdef LCD_BUS_LOCK_EN
        if (m_lock_act && (req_valid[m_lock_own] || req_lock[m_lock_own]))
            return req_valid[m_lock_own] ? (2'b01 << m_lock_own) : 2'b00;
`endif
        if (req_valid == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin : cmp
            int         k, sel, wait_len;
            logic [1:0] e_ready, e_done;
            bit         e_en;
            k       = cyc - m_acc_cyc;
            e_ready = (!m_active && !rst) ? modelGrant() : 2'b00;
            e_en    = m_active && k >= TS + 1 && k <= TS + TP;
            e_done  = (m_active && k == m_dur && !rst) ? (2'b01 << m_owner) : 2'b00;

            checkOutput("req_ready", int'(req_ready), int'(e_ready));
            checkOutput("req_done", int'(req_done), int'(e_done));
            checkOutput("busy", int'(busy), int'(m_active));
            checkOutput("lcd_en", int'(lcd_en), int'(e_en));
            checkOutput("lcd_rs", int'(lcd_rs), int'(m_rs));
            checkOutput("lcd_db", int'(lcd_db), int'(m_db));
            checkOutput("lcd_rw", int'(lcd_rw), 0);
            checkOutput("lcd_psb", int'(lcd_psb), 1);

            if (|(req_valid & req_ready)) begin
                d_owners.push_back(req_ready[1] ? 1 : 0);
                d_acc_cyc = cyc;
                d_rise    = -1;
                d_len     = 0;
                d_done    = -1;
            end
            if (lcd_en) begin
                d_len++;
                if (!d_prev_en) d_rise = cyc - d_acc_cyc;
            end
            if (req_done != 2'b00) d_done = cyc - d_acc_cyc;
            d_prev_en = lcd_en;

            if (rst) begin
                m_active   = 0;
                m_rs       = 0;
                m_db       = 8'h00;
                m_last     = 1;
                m_lock_act = 0;
                m_lock_own = 0;
            end else if (m_active) begin
                if (k == m_dur) m_active = 0;
            end else if (e_ready != 2'b00) begin
                sel        = e_ready[1] ? 1 : 0;
                m_rs       = req_rs[sel];
                m_db       = req_db[sel*8 +: 8];
                wait_len   = (!m_rs && (m_db == 8'h01 || m_db == 8'h02)) ? TC : TE;
                m_dur      = TS + TP + TH + wait_len;
                m_active   = 1;
                m_acc_cyc  = cyc;
                m_owner    = sel;
                m_last     = sel;
                m_lock_act = req_lock[sel];
                m_lock_own = sel;
                m_acc_cnt[sel]++;
            end else if (m_lock_act && !req_valid[m_lock_own] && !req_lock[m_lock_own]) begin
                m_lock_act = 0;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input bit rs, input logic [7:0] db, input bit lock);
        int start, n;
        start            = m_acc_cnt[port];
        req_valid[port]  = 1'b1;
        req_rs[port]     = rs;
        req_db[port*8 +: 8] = db;
        req_lock[port]   = lock;
        n = 0;
        while (m_acc_cnt[port] == start && n < 300) begin
            tick();
            n++;
        end
        if (m_acc_cnt[port] == start) checkOutput("accept_timeout", 0, 1);
        req_valid[port] = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (m_active && n < 300) begin
            tick();
            n++;
        end
        if (m_active) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic checkWriteTiming(input string tag, input int done_lat);
        checkOutput({tag, "_en_rise"}, d_rise, 3);
        checkOutput({tag, "_en_len"}, d_len, 3);
        checkOutput({tag, "_done_lat"}, d_done, done_lat);
    endtask

    initial begin
        int n, base, oq_start, a0, a1;
        int exp_lock[4];
`ifdef LCD_BUS_LOCK_EN
        exp_lock = '{1, 1, 1, 0};
`else
        exp_lock = '{1, 0, 1, 1};
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset during EN pulse");
        req_valid[0] = 1'b1; req_rs[0] = 1'b1; req_db[7:0] = 8'h5A; req_lock = 2'b00;
        n = 0;
        while (m_acc_cnt[0] == 0 && n < 50) begin tick(); n++; end
        req_valid = 2'b00;
        n = 0;
        while (cyc - m_acc_cyc < TS + 2 && n < 50) begin tick(); n++; end
        rst = 1'b1;
        req_valid = 2'b11; req_rs = 2'b11; req_db = 16'h6261;
        tick();
        checkOutput("rst_lcd_en", int'(lcd_en), 0);
        checkOutput("rst_lcd_db", int'(lcd_db), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_ready", int'(req_ready), 0);
        tick();
        tick();
        checkOutput("rst_no_done", d_done, -1);
        rst = 1'b0;
        base = m_acc_cnt[0] + m_acc_cnt[1];
        n = 0;
        while (m_acc_cnt[0] + m_acc_cnt[1] == base && n < 50) begin tick(); n++; end
        req_valid = 2'b00;
        if (d_owners.size() > 0) checkOutput("first_after_rst", d_owners[d_owners.size()-1], 0);
        else checkOutput("first_after_rst_missing", 0, 1);
        waitIdle();

        $display("[TB] single writes and clear wait");
        applyStimulus(0, 1'b0, 8'h30, 1'b0);
        waitIdle();
        checkWriteTiming("instr30", 16);
        applyStimulus(0, 1'b0, 8'h01, 1'b0);
        waitIdle();
        checkWriteTiming("clear01", 46);
        applyStimulus(0, 1'b1, 8'h01, 1'b0);
        waitIdle();
        checkWriteTiming("data01", 16);
        applyStimulus(1, 1'b0, 8'h02, 1'b0);
        waitIdle();
        checkWriteTiming("home02", 46);

        $display("[TB] round robin");
        oq_start = d_owners.size();
        base = m_acc_cnt[0] + m_acc_cnt[1];
        req_valid = 2'b11; req_rs = 2'b11; req_db = 16'h2211; req_lock = 2'b00;
        n = 0;
        while (m_acc_cnt[0] + m_acc_cnt[1] < base + 6 && n < 400) begin tick(); n++; end
        req_valid = 2'b00;
        waitIdle();
        if (d_owners.size() >= oq_start + 6) begin
            for (int i = 0; i < 6; i++) checkOutput("rr_owner", d_owners[oq_start+i], i % 2);
        end else checkOutput("rr_accepts", d_owners.size() - oq_start, 6);

        $display("[TB] locked line write");
        oq_start = d_owners.size();
        base = m_acc_cnt[1];
        a0 = m_acc_cnt[0];
        req_valid[1] = 1'b1; req_rs[1] = 1'b0; req_db[15:8] = 8'h80; req_lock[1] = 1'b1;
        n = 0;
        while ((m_acc_cnt[1] - base < 3 || m_acc_cnt[0] - a0 < 1) && n < 400) begin
            tick();
            n++;
            a1 = m_acc_cnt[1] - base;
            if (a1 == 1) begin
                req_rs[1] = 1'b1; req_db[15:8] = 8'hA3; req_lock[1] = 1'b1;
                if (m_acc_cnt[0] == a0) begin
                    req_valid[0] = 1'b1; req_rs[0] = 1'b1; req_db[7:0] = 8'h44; req_lock[0] = 1'b0;
                end
            end
            if (a1 == 2) begin req_db[15:8] = 8'hB3; req_lock[1] = 1'b0; end
            if (a1 >= 3) req_valid[1] = 1'b0;
            if (m_acc_cnt[0] != a0) req_valid[0] = 1'b0;
        end
        req_valid = 2'b00;
        req_lock = 2'b00;
        waitIdle();
        if (d_owners.size() >= oq_start + 4) begin
            for (int i = 0; i < 4; i++) checkOutput("lock_owner", d_owners[oq_start+i], exp_lock[i]);
        end else checkOutput("lock_accepts", d_owners.size() - oq_start, 4);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) req_valid[p] = ~req_valid[p];
                req_rs[p] = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 5))
                    0:       req_db[p*8 +: 8] = 8'h01;
                    1:       req_db[p*8 +: 8] = 8'h02;
                    default: req_db[p*8 +: 8] = 8'($urandom_range(0, 255));
                endcase
                req_lock[p] = $urandom_range(0, 2) == 0;
            end
            tick();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        req_lock = 2'b00;
        waitIdle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the QC12864B/ST7920 8-bit parallel write bus between two requesters and generates all bus timing. Each request is one RS/DB write. The block produces the setup, EN-pulse and hold phases, then waits out the controller execution time before the next write. It sits between the LCD pins and the upstream sequencers: port 0 is the init/command sequencer, port 1 is the text/page writer. This lets neither upstream block derive EN from a divided clock.

## Interface
Parameters (cycle counts at 50 MHz, each ≥1):
- T_SETUP, 4, cycles RS/DB are stable before EN rises
- T_PULSE, 25, EN high cycles (500 ns)
- T_HOLD, 5, cycles RS/DB are held after EN falls
- T_EXEC, 3600, execution wait for ordinary writes (72 µs)
- T_CLEAR, 80000, execution wait after command 0x01 or 0x02 (1.6 ms)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  2  per-requester write request
- req_rs  in  2  per-requester RS (1 = data, 0 = instruction)
- req_db  in  16  per-requester byte; [7:0] is port 0, [15:8] is port 1
- req_lock  in  2  owner keeps the bus after its current write
- req_ready  out  2  accept strobe; transfer happens when valid & ready
- req_done  out  2  one-cycle pulse marking the end of the owner's write execution
- busy  out  1  high whenever the state is not IDLE
- lcd_rs  out  1  RS pin
- lcd_rw  out  1  RW pin; constant 0
- lcd_en  out  1  EN pin; registered
- lcd_db  out  8  DB pin; registered, always driven
- lcd_psb  out  1  PSB pin; constant 1 (parallel mode)

## Operation
- States and transitions:
  - IDLE → SETUP on accept.
  - SETUP (T_SETUP cycles) → PULSE (T_PULSE) → HOLD (T_HOLD) → WAIT (T_EXEC or T_CLEAR) → IDLE.
- On accept, the block latches RS, DB and the owner index.
  - lcd_rs and lcd_db take the latched values on the first SETUP cycle.
  - They hold those values through WAIT and keep them in IDLE until the next accept.
- lcd_en is 1 only during PULSE.
- WAIT length is T_CLEAR when latched RS=0 and DB ∈ {0x01, 0x02}; otherwise T_EXEC.
- A single down-counter covers all phases.
  - It is loaded with N−1 on phase entry; the phase ends in the cycle the counter reads 0.
  - Width is $clog2(max parameter + 1); the counter never wraps.
- req_ready[i] is combinational: (state == IDLE) & grant[i] & !rst.
- Round-robin arbitration:
  - A `last` register records the previous owner.
  - With both requesters valid, the non-`last` port is granted.
  - With one valid, that port is granted.
  - `last` is updated on each accept.
- req_done[owner] pulses in the final WAIT cycle. An accept is possible in the following IDLE cycle.
- req_valid deasserted before accept cancels nothing; no state changes.
- Reset values: state IDLE, last=1 (port 0 favoured first), lcd_en=0, lcd_rs=0, lcd_db=0x00, req_done=0, busy=0, lock owner cleared.
- Reset mid-operation: on the next edge lcd_en drops to 0 and everything returns to reset values. The aborted write is never reported done.

## Timing
- Accept edge to lcd_en rise: T_SETUP+1 edges. lcd_en is high for exactly T_PULSE cycles.
- Accept edge to req_done pulse: T_SETUP+T_PULSE+T_HOLD+T_wait cycles.
- Minimum accept-to-accept spacing: that figure plus 1.
- busy rises on the edge after accept and falls on the edge after the req_done cycle.
- lcd_db and lcd_rs never change while lcd_en=1, nor during HOLD.

## Configuration
- LCD_BUS_LOCK_EN defined:
  - An owner whose req_lock is high at its accept keeps exclusive grant.
  - The other port's req_ready stays 0 until that owner is accepted with req_lock=0, or is idle in IDLE with req_lock=0.
  - Used for address-plus-16-character line writes.
- Undefined: req_lock is ignored and pure round-robin applies per write. The ports remain present.

## Test plan
Bench parameters: T_SETUP=2, T_PULSE=3, T_HOLD=1, T_EXEC=10, T_CLEAR=40.
- Reset check: assert rst for 3 cycles, with req_valid high on both ports, during a PULSE phase.
  - lcd_en=0 on the next edge; lcd_db=0x00, busy=0, req_ready=0 while rst is high, no req_done.
  - After release, port 0 is accepted first.
- Single instruction: port 0 writes RS=0, DB=0x30.
  - lcd_en rises 3 edges after accept and stays high 3 cycles.
  - req_done[0] pulses 16 cycles after accept.
- Clear wait: port 0 writes RS=0, DB=0x01, giving req_done 46 cycles after accept.
  - RS=1, DB=0x01 gives 16 cycles.
- Round-robin: both ports hold valid continuously for 6 writes.
  - Grants alternate 0,1,0,1,0,1; lcd_db is never changed while lcd_en=1.
- Lock (macro on): port 1 writes 0x80 then 0xA3,0xB3 with req_lock=1, last write with req_lock=0, while port 0 is valid.
  - All three port-1 writes complete before port 0 is accepted.
  - With the macro off, the grants interleave instead.
